des_subkey_stream: RTL
======================

DES_SUBKEY_STREAM -- requirements
Module: des_subkey_stream

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 1, legal values 1 (single DES) or 3 (3DES EDE key bundle).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request, accepted only in IDLE.
REQ-005 SHALL have port decrypt  input  1  mode, sampled with accepted start; 0 = encrypt, 1 = decrypt.
REQ-006 SHALL have port key_in  input  64*NUM_KEYS  keys; key k in bits [64k+63:64k], DES bit 1 = bit 64k+63.
REQ-007 SHALL have port sk_ready  input  1  downstream accepts the current subkey.
REQ-008 SHALL have port sk_valid  output  1  sk_data/sk_round/sk_key_idx/sk_last are valid.
REQ-009 SHALL have port sk_data  output  48  subkey, DES bit 1 = bit 47.
REQ-010 SHALL have port sk_round  output  4  DES subkey number minus 1 (0..15).
REQ-011 SHALL have port sk_key_idx  output  2  index of the source key (0..NUM_KEYS-1).
REQ-012 SHALL have port sk_last  output  1  high with the final subkey of the whole sequence.
REQ-013 SHALL have ports busy  output  1  (high outside IDLE) and done  output  1  (one-cycle pulse at end).

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> RUN -> (LOAD for next pass | DONE) -> IDLE.
REQ-015 On accepted start (IDLE, start=1) SHALL register key_in and decrypt, apply PC-1 to the first pass key, and enter LOAD.
REQ-016 LOAD SHALL apply the first rotation of the pass (encrypt: rotl 1; decrypt: none) and register PC-2 into sk_data; RUN follows.
REQ-017 In RUN, on sk_valid&&sk_ready SHALL advance: encrypt rotl by shift[n+1], decrypt rotr by shift[n], n = current DES subkey number; shift = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-018 Encrypt pass SHALL emit K1..K16 (sk_round 0..15); decrypt pass SHALL emit K16..K1 (sk_round 15..0).
REQ-019 NUM_KEYS=1: one pass using key 0, mode = decrypt.
REQ-020 NUM_KEYS=3, decrypt=0: passes key0 enc, key1 dec, key2 enc; decrypt=1: key2 dec, key1 enc, key0 dec.
REQ-021 Between passes SHALL take exactly one LOAD bubble cycle (sk_valid=0), reloading C,D via PC-1 from the next key.
REQ-022 While sk_valid=1 and sk_ready=0, all sk_* outputs SHALL hold stable.
REQ-023 Latency: accepted start at cycle t -> first sk_valid at t+2; with sk_ready held 1, NUM_KEYS=1 emits on t+2..t+17, done at t+18.
REQ-024 done SHALL pulse the cycle after the sk_last handshake; FSM returns to IDLE the same cycle; start in that cycle is ignored.
REQ-025 start while busy SHALL be ignored; key_in/decrypt changes while busy SHALL not affect the sequence.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE from any state, including mid-pass, discarding the sequence.
REQ-027 Reset values: sk_valid 0, sk_data 0, sk_round 0, sk_key_idx 0, sk_last 0, busy 0, done 0, parity_err 0.

Configuration
REQ-028 Macro DES_KEY_PARITY_CHECK_EN SHALL, when defined, add output parity_err (1 bit) and check odd parity of every key byte at accepted start.
REQ-029 With macro, any failing byte: parity_err=1 from t+1 until next accepted start, no sk_valid, LOAD skipped, done pulses at t+2.
REQ-030 Without macro, parity_err port SHALL not exist and parity bits SHALL be ignored.

Verification
REQ-031 NUM_KEYS=1, key 133457799BBCDFF1, decrypt=0, ready=1 -> sk_data 1B02EFFC7072 at t+2, CB3D8B0E17F5 at t+17 with sk_last, done at t+18.
REQ-032 Same key, decrypt=1 -> first CB3D8B0E17F5 sk_round 15, last 1B02EFFC7072 sk_round 0.
REQ-033 Ready low t+2..t+4 -> sk_data held 1B02EFFC7072 with sk_valid=1; second subkey only after ready returns.
REQ-034 NUM_KEYS=3, three copies of the key, decrypt=0 -> 48 subkeys K1..K16, K16..K1, K1..K16; bubbles at t+18, t+35; last at t+51, done t+52.
REQ-035 rst pulsed at t+8 of a run -> all outputs at reset values next cycle; new start at t+10 -> first sk_valid at t+12.
REQ-036 Macro defined, key 133457799BBCDFF0 -> parity_err=1 at t+1, sk_valid never 1, done at t+2.

Source files
------------

// File: rtl/des_subkey_stream.sv
// DES key-schedule subkey streamer (single DES or 3DES EDE bundle) with a valid/ready output.
// Optional key-byte odd-parity checking is enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_subkey_stream #(
  parameter int NUM_KEYS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   decrypt,
  input  logic [64*NUM_KEYS-1:0] key_in,
  input  logic                   sk_ready,
  output logic                   sk_valid,
  output logic [47:0]            sk_data,
  output logic [3:0]             sk_round,
  output logic [1:0]             sk_key_idx,
  output logic                   sk_last,
  output logic                   busy,
  output logic                   done
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic                   parity_err
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, ERR, DONE} state_t;

  localparam logic [1:0] LAST_PASS = 2'(NUM_KEYS - 1);

  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4};

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

  // Table entries are DES bit numbers (1 = MSB).
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = 56'd0;
    for (int i = 0; i < 56; i++) r[55 - i] = k[6'(7'd64 - {1'b0, PC1_TAB[i]})];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = 48'd0;
    for (int i = 0; i < 48; i++) r[47 - i] = cd[6'd56 - PC2_TAB[i]];
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic two);
    logic [27:0] r;
    if (left) r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    else      r = two ? {x[1:0], x[27:2]}   : {x[0], x[27:1]};
    return r;
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic left, input logic two);
    return {rot28(cd[55:28], left, two), rot28(cd[27:0], left, two)};
  endfunction

  // Shift schedule indexed by subkey number minus 1: two-bit shifts except 1, 2, 9, 16.
  function automatic logic shift_two(input logic [3:0] idx);
    logic r;
    case (idx)
      4'd0, 4'd1, 4'd8, 4'd15: r = 1'b0;
      default:                 r = 1'b1;
    endcase
    return r;
  endfunction

`ifdef DES_KEY_PARITY_CHECK_EN
  function automatic logic parity_ok(input logic [64*NUM_KEYS-1:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8 * NUM_KEYS; i++) ok = ok & (^k[8*i +: 8]);
    return ok;
  endfunction
`endif

  state_t                 state_r;
  logic [64*NUM_KEYS-1:0] keys_r;
  logic                   dec_r;
  logic [1:0]             pass_r;
  logic [55:0]            cd_r;

  logic        cur_dec_s, end_of_pass_s, next_last_s;
  logic [1:0]  cur_idx_s, next_pass_s, next_idx_s, first_idx_s;
  logic [3:0]  next_round_s;
  logic [55:0] adv_cd_s, load_cd_s;
  logic [63:0] next_key_s, first_key_s;

  // Pass sequencing and next C,D values; the middle EDE pass runs in the opposite mode.
  always_comb begin
    cur_dec_s     = dec_r ^ (pass_r == 2'd1);
    cur_idx_s     = dec_r ? (LAST_PASS - pass_r) : pass_r;
    next_pass_s   = pass_r + 2'd1;
    next_idx_s    = dec_r ? (LAST_PASS - next_pass_s) : next_pass_s;
    first_idx_s   = decrypt ? LAST_PASS : 2'd0;
    next_key_s    = keys_r[64*next_idx_s +: 64];
    first_key_s   = key_in[64*first_idx_s +: 64];
    end_of_pass_s = cur_dec_s ? (sk_round == 4'd0) : (sk_round == 4'd15);
    next_round_s  = cur_dec_s ? (sk_round - 4'd1) : (sk_round + 4'd1);
    next_last_s   = (pass_r == LAST_PASS) && (next_round_s == (cur_dec_s ? 4'd0 : 4'd15));
    adv_cd_s      = cur_dec_s ? rot_cd(cd_r, 1'b0, shift_two(sk_round))
                              : rot_cd(cd_r, 1'b1, shift_two(next_round_s));
    load_cd_s     = cur_dec_s ? cd_r : rot_cd(cd_r, 1'b1, 1'b0);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      keys_r     <= {(64*NUM_KEYS){1'b0}};
      dec_r      <= 1'b0;
      pass_r     <= 2'd0;
      cd_r       <= 56'd0;
      sk_valid   <= 1'b0;
      sk_data    <= 48'd0;
      sk_round   <= 4'd0;
      sk_key_idx <= 2'd0;
      sk_last    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            keys_r <= key_in;
            dec_r  <= decrypt;
            pass_r <= 2'd0;
            cd_r   <= pc1(first_key_s);
            busy   <= 1'b1;
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_err <= ~parity_ok(key_in);
            state_r    <= parity_ok(key_in) ? LOAD : ERR;
`else
            state_r <= LOAD;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          cd_r       <= load_cd_s;
          sk_data    <= pc2(load_cd_s);
          sk_round   <= cur_dec_s ? 4'd15 : 4'd0;
          sk_key_idx <= cur_idx_s;
          sk_last    <= 1'b0;
          sk_valid   <= 1'b1;
          state_r    <= RUN;
        end
        RUN: begin
          if (sk_ready) begin
            if (end_of_pass_s) begin
              sk_valid <= 1'b0;
              sk_last  <= 1'b0;
              if (sk_last) begin
                done    <= 1'b1;
                state_r <= DONE;
              end else begin
                pass_r  <= next_pass_s;
                cd_r    <= pc1(next_key_s);
                state_r <= LOAD;
              end
            end else begin
              cd_r     <= adv_cd_s;
              sk_data  <= pc2(adv_cd_s);
              sk_round <= next_round_s;
              sk_last  <= next_last_s;
            end
          end
        end
        ERR: begin
          done    <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          sk_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
